// File: rtl/osd_candidate_generator.sv
// Streams base^pattern for every weight-1 then weight-2 error pattern, one per valid/ready transfer.
// Optional macro OSD_GEN_ORDER0_EN prepends the all-zero pattern (candidate equals base).
module osd_candidate_generator #(
   parameter int K         = 32,
   parameter int TOTAL     = K + K*(K-1)/2,
   parameter int IDX_WIDTH = $clog2(TOTAL+2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [K-1:0]         base_word,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [K-1:0]         cand_out,
   output logic [K-1:0]         pattern_out,
   output logic [IDX_WIDTH-1:0] cand_idx,
   output logic                 cand_last,
   output logic                 busy,
   output logic                 done
);
   localparam int CW = $clog2(K) + 1;
   localparam logic [CW-1:0] I_LAST  = CW'(K-1);
   // Wraps for K=1, where ORD2 is never entered.
   localparam logic [CW-1:0] I2_LAST = CW'(K-2);
`ifdef OSD_GEN_ORDER0_EN
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(TOTAL);
`else
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(TOTAL-1);
`endif

   typedef enum logic [2:0] {IDLE, ORD0, ORD1, ORD2, FIN} state_t;

   state_t               state, state_nxt;
   logic [K-1:0]         base_q;
   logic [CW-1:0]        i_q, j_q;
   logic [IDX_WIDTH-1:0] idx_q;
   logic                 xfer;

   assign xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef OSD_GEN_ORDER0_EN
               state_nxt = ORD0;
`else
               state_nxt = ORD1;
`endif
            end
         end
         ORD0: begin
            if (abort)     state_nxt = IDLE;
            else if (xfer) state_nxt = ORD1;
         end
         ORD1: begin
            if (abort)                          state_nxt = IDLE;
            else if (xfer && (i_q == I_LAST))   state_nxt = (K >= 2) ? ORD2 : FIN;
         end
         ORD2: begin
            if (abort) state_nxt = IDLE;
            else if (xfer && (i_q == I2_LAST) && (j_q == I_LAST)) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pair (i,j) walks lexicographically; after (i,K-1) the next pair is (i+1,i+2).
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= '0;
         i_q    <= '0;
         j_q    <= CW'(1);
         idx_q  <= '0;
      end else if ((state == IDLE) && start) begin
         base_q <= base_word;
         i_q    <= '0;
         j_q    <= CW'(1);
         idx_q  <= '0;
      end else if (xfer && !abort) begin
         idx_q <= idx_q + IDX_WIDTH'(1);
         case (state)
            ORD1: begin
               if (i_q == I_LAST) begin
                  i_q <= '0;
                  j_q <= CW'(1);
               end else begin
                  i_q <= i_q + CW'(1);
               end
            end
            ORD2: begin
               if (j_q == I_LAST) begin
                  i_q <= i_q + CW'(1);
                  j_q <= i_q + CW'(2);
               end else begin
                  j_q <= j_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      pattern_out = '0;
      case (state)
         ORD0: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         ORD1: begin
            out_valid   = 1'b1;
            busy        = 1'b1;
            pattern_out = K'(1) << i_q;
         end
         ORD2: begin
            out_valid   = 1'b1;
            busy        = 1'b1;
            pattern_out = (K'(1) << i_q) | (K'(1) << j_q);
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
      cand_out  = out_valid ? (base_q ^ pattern_out) : '0;
      cand_idx  = out_valid ? idx_q : '0;
      cand_last = out_valid && (idx_q == IDX_LAST);
   end
endmodule

// File: tb/tb_osd_candidate_generator.sv
// Scoreboard bench for osd_candidate_generator with K=4 and K=1 instances.
// Expected candidates come from nested-loop pattern enumeration, queued at start and popped per transfer.
module tb_osd_candidate_generator;
   localparam int K4  = 4;
   localparam int T4  = K4 + K4*(K4-1)/2;
   localparam int IW4 = $clog2(T4+2);
   localparam int T1  = 1;
   localparam int IW1 = $clog2(T1+2);
`ifdef OSD_GEN_ORDER0_EN
   localparam int N4 = T4 + 1;
   localparam int N1 = T1 + 1;
`else
   localparam int N4 = T4;
   localparam int N1 = T1;
`endif

   typedef struct {
      logic [3:0] pat;
      logic [3:0] cand;
      int         idx;
      bit         last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           start4, abort4, ready4, valid4, last4, busy4, done4;
   logic [3:0]     base4, cand4, pattern4;
   logic [IW4-1:0] idx4;
   logic           start1, abort1, ready1, valid1, last1, busy1, done1;
   logic [0:0]     base1, cand1, pattern1;
   logic [IW1-1:0] idx1;

   exp_t q4[$];
   exp_t q1[$];
   int   errors = 0;
   int   checks = 0;

   osd_candidate_generator #(.K(K4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4), .base_word(base4),
      .out_valid(valid4), .out_ready(ready4), .cand_out(cand4), .pattern_out(pattern4),
      .cand_idx(idx4), .cand_last(last4), .busy(busy4), .done(done4)
   );

   osd_candidate_generator #(.K(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .base_word(base1),
      .out_valid(valid1), .out_ready(ready1), .cand_out(cand1), .pattern_out(pattern1),
      .cand_idx(idx1), .cand_last(last1), .busy(busy1), .done(done1)
   );

   task automatic push_one(input logic [3:0] p, input logic [3:0] b, inout int n);
      exp_t e;
      e.pat  = p;
      e.cand = b ^ p;
      e.idx  = n;
      e.last = (n == N4-1);
      q4.push_back(e);
      n++;
   endtask

   task automatic push_model4(input logic [3:0] b);
      int n;
      n = 0;
`ifdef OSD_GEN_ORDER0_EN
      push_one(4'b0000, b, n);
`endif
      for (int a = 0; a < K4; a++) push_one(4'b0001 << a, b, n);
      for (int a = 0; a < K4; a++)
         for (int c = a + 1; c < K4; c++)
            push_one((4'b0001 << a) | (4'b0001 << c), b, n);
   endtask

   // One K=4 run: optional stall on a pattern, start poke mid-run, or cut by rst/abort at an index.
   task automatic drive_run(input logic [3:0] b, input logic [3:0] stall_pat, input int stall_len,
                            input int poke_at, input int cut_idx, input bit cut_abort);
      exp_t e;
      int   s, xfers, stalled;
      bit   fin;
      q4.delete();
      push_model4(b);
      s = 0; xfers = 0; stalled = 0; fin = 0;
      start4 = 1'b1;
      base4  = b;
      @(negedge clk);
      start4 = 1'b0;
      base4  = ~b;
      while (!fin && s < 200) begin
         s++;
         ready4 = 1'b1;
         start4 = (s == poke_at);
         if (s == poke_at) base4 = 4'($urandom);
         if (q4.size() > 0 && q4[0].pat == stall_pat && stalled < stall_len) begin
            ready4 = 1'b0;
            stalled++;
         end
         #1;
         if (s == 1) begin
            checks++;
            if (valid4 !== 1'b1) begin
               errors++;
               $display("FAIL first_latency out_valid=%b expected 1", valid4);
            end
         end
         if (valid4 === 1'b1) begin
            if (q4.size() == 0) begin
               checks++; errors++;
               $display("FAIL extra_cand idx=%0d pat=%b", idx4, pattern4);
               fin = 1;
            end else begin
               e = q4[0];
               checks++;
               if ({pattern4, cand4, idx4, last4, busy4, done4} !==
                   {e.pat, e.cand, IW4'(e.idx), e.last, 1'b1, 1'b0}) begin
                  errors++;
                  $display("FAIL cand got pat=%b cand=%b idx=%0d last=%b busy=%b done=%b exp pat=%b cand=%b idx=%0d last=%b",
                           pattern4, cand4, idx4, last4, busy4, done4, e.pat, e.cand, e.idx, e.last);
               end
               if (e.idx == cut_idx) begin
                  if (cut_abort) abort4 = 1'b1;
                  else           rst    = 1'b1;
                  @(negedge clk);
                  abort4 = 1'b0;
                  rst    = 1'b0;
                  for (int c = 0; c < 3; c++) begin
                     #1;
                     checks++;
                     if ({valid4, busy4, done4} !== 3'b000) begin
                        errors++;
                        $display("FAIL cut_idle valid=%b busy=%b done=%b expected 000", valid4, busy4, done4);
                     end
                     @(negedge clk);
                  end
                  q4.delete();
                  fin = 1;
               end else if (ready4) begin
                  void'(q4.pop_front());
                  xfers++;
               end
            end
         end else if (done4 === 1'b1) begin
            checks++;
            if (q4.size() != 0 || xfers != N4 || s != N4 + 1 + stall_len) begin
               errors++;
               $display("FAIL done_timing left=%0d xfers=%0d cycle=%0d expected 0 %0d %0d",
                        q4.size(), xfers, s, N4, N4 + 1 + stall_len);
            end
            fin = 1;
            start4 = 1'b1;  // ignored: FSM is in FIN
            @(negedge clk);
            start4 = 1'b0;
            #1;
            checks++;
            if ({valid4, busy4, done4} !== 3'b000) begin
               errors++;
               $display("FAIL post_done valid=%b busy=%b done=%b expected 000", valid4, busy4, done4);
            end
         end else begin
            checks++; errors++;
            $display("FAIL gap cycle=%0d valid=0 done=0 mid-run", s);
            fin = 1;
         end
         if (!fin) @(negedge clk);
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL timeout run never finished");
      end
      start4 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({valid4, cand4, pattern4, idx4, last4, busy4, done4} !== '0) begin
         errors++;
         $display("FAIL reset4 valid=%b cand=%b pat=%b idx=%0d last=%b busy=%b done=%b expected all 0",
                  valid4, cand4, pattern4, idx4, last4, busy4, done4);
      end
      checks++;
      if ({valid1, cand1, pattern1, idx1, last1, busy1, done1} !== '0) begin
         errors++;
         $display("FAIL reset1 valid=%b cand=%b idx=%0d done=%b expected all 0", valid1, cand1, idx1, done1);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_order_base0;   drive_run(4'b0000, 4'b1111, 0, -1, -1, 0); endtask
   task automatic test_base1010;      drive_run(4'b1010, 4'b1111, 0, -1, -1, 0); endtask
   task automatic test_stall;         drive_run(4'b0111, 4'b0101, 3, -1, -1, 0); endtask
   task automatic test_start_busy;    drive_run(4'b1100, 4'b1111, 0, 4, -1, 0); endtask

   task automatic test_restart_rst;
      drive_run(4'b0110, 4'b1111, 0, -1, 7, 0);
      drive_run(4'b0110, 4'b1111, 0, -1, -1, 0);
   endtask

   task automatic test_restart_abort;
      drive_run(4'b0110, 4'b1111, 0, -1, 7, 1);
      drive_run(4'b0110, 4'b1111, 0, -1, -1, 0);
   endtask

   task automatic test_abort_idle;
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      #1;
      checks++;
      if ({valid4, busy4, done4} !== 3'b000) begin
         errors++;
         $display("FAIL abort_idle valid=%b busy=%b done=%b expected 000", valid4, busy4, done4);
      end
      start4 = 1'b1;
      abort4 = 1'b1;
      base4  = 4'b0011;
      @(negedge clk);
      start4 = 1'b0;
      abort4 = 1'b0;
      #1;
      checks++;
      if ({valid4, cand4, idx4} !== {1'b1, (N4 == T4) ? 4'b0010 : 4'b0011, IW4'(0)}) begin
         errors++;
         $display("FAIL start_wins valid=%b cand=%b idx=%0d", valid4, cand4, idx4);
      end
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
   endtask

   task automatic test_k1;
      exp_t e;
      int   s;
      bit   fin;
      q1.delete();
`ifdef OSD_GEN_ORDER0_EN
      e.pat = 4'b0000; e.cand = 4'b0001; e.idx = 0; e.last = 1'b0; q1.push_back(e);
      e.pat = 4'b0001; e.cand = 4'b0000; e.idx = 1; e.last = 1'b1; q1.push_back(e);
`else
      e.pat = 4'b0001; e.cand = 4'b0000; e.idx = 0; e.last = 1'b1; q1.push_back(e);
`endif
      start1 = 1'b1;
      base1  = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      base1  = 1'b0;
      s = 0; fin = 0;
      while (!fin && s < 20) begin
         s++;
         #1;
         if (valid1 === 1'b1 && q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({pattern1, cand1, idx1, last1} !== {e.pat[0], e.cand[0], IW1'(e.idx), e.last}) begin
               errors++;
               $display("FAIL k1_cand got pat=%b cand=%b idx=%0d last=%b exp pat=%b cand=%b idx=%0d last=%b",
                        pattern1, cand1, idx1, last1, e.pat[0], e.cand[0], e.idx, e.last);
            end
         end else if (done1 === 1'b1) begin
            checks++;
            if (q1.size() != 0 || s != N1 + 1) begin
               errors++;
               $display("FAIL k1_done left=%0d cycle=%0d expected 0 %0d", q1.size(), s, N1 + 1);
            end
            fin = 1;
         end
         @(negedge clk);
      end
      if (!fin) begin
         checks++; errors++;
         $display("FAIL k1_timeout no done");
      end
   endtask

   initial begin
      rst = 1'b1;
      start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b1; base4 = '0;
      start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; base1 = '0;
      @(negedge clk);
      test_reset;
      test_order_base0;
      test_base1010;
      test_stall;
      test_restart_rst;
      test_restart_abort;
      test_abort_idle;
      test_k1;
      test_start_busy;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
